// File: rtl/mc_fifo_pkg.sv
// Shared definitions for the multi-channel FIFO: width helpers and error-flag layout.
package mc_fifo_pkg;

  // Bit positions inside the sticky error register.
  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_UDF_BIT = 1;
  localparam int ERR_W       = 2;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int cw_of(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Level width: enough to hold 0..depth inclusive.
  function automatic int lw_of(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mc_fifo_mem.sv
// Simple dual-port storage: one write port and one read port.
// SHOWAHEAD=0 gives registered read data one cycle after rd_en.
module mc_fifo_mem #(
  parameter int WIDTH_BYTES = 4,
  parameter int DEPTH       = 64,
  parameter int SHOWAHEAD   = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = WIDTH_BYTES * 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      assign rd_data = mem[rd_addr];
    end else begin : g_registered
      // Registered read port; output holds between reads.
      always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
      end
    end
  endgenerate

endmodule

// File: rtl/mc_fifo.sv
// Multi-channel FIFO: CHANNELS independent queues sharing one memory,
// one push and one pop per cycle, sticky overflow/underflow flags,
// per-channel flush and registered almost-full.
module mc_fifo
  import mc_fifo_pkg::*;
#(
  parameter int WIDTH_BYTES  = 4,
  parameter int DEPTH        = 16,
  parameter int CHANNELS     = 4,
  parameter int AFULL_THRESH = 12,
  localparam int CW = cw_of(CHANNELS),
  localparam int LW = lw_of(DEPTH),
  localparam int DW = WIDTH_BYTES * 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_in,
  input  logic [CW-1:0]       push_ch_in,
  input  logic [DW-1:0]       data_in,
  input  logic                pop_in,
  input  logic [CW-1:0]       pop_ch_in,
  output logic [DW-1:0]       data_out,
  output logic                data_valid_out,
  output logic [CW-1:0]       data_ch_out,
  output logic [CHANNELS-1:0] empty_out,
  output logic [CHANNELS-1:0] full_out,
  output logic [CHANNELS-1:0] afull_out,
  output logic [LW-1:0]       level_out,
  input  logic                clear_in,
  input  logic [CW-1:0]       clear_ch_in,
  output logic                overflow_out,
  output logic                underflow_out,
  input  logic                err_clr_in,
  input  logic                debugen_in
);

  localparam int PW = LW - 1;
  localparam int AW = CW + PW;
  localparam logic [LW-1:0] CNT_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] CNT_AFULL = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] CNT_ONE   = LW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [PW-1:0]       wp_q    [CHANNELS];
  logic [PW-1:0]       rp_q    [CHANNELS];
  logic [LW-1:0]       cnt_q   [CHANNELS];
  logic [PW-1:0]       wp_nxt  [CHANNELS];
  logic [PW-1:0]       rp_nxt  [CHANNELS];
  logic [LW-1:0]       cnt_nxt [CHANNELS];
  logic [ERR_W-1:0]    err_q;
  logic                dv_q;
  logic [CW-1:0]       dch_q;
  logic                push_blk, pop_blk;
  logic                push_acc, pop_acc, push_rej, pop_rej;
  logic [CHANNELS-1:0] push_hit, pop_hit, clr_hit;
  logic [AW-1:0]       wr_addr, rd_addr;

  // Per-channel empty/full straight from the counts.
  always_comb begin
    empty_out = '0;
    full_out  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      empty_out[c] = (cnt_q[c] == '0);
      full_out[c]  = (cnt_q[c] == CNT_FULL);
    end
  end

  assign level_out = cnt_q[pop_ch_in];

  // Accept/reject decisions; a flush swallows same-channel traffic silently.
  always_comb begin
    push_blk = clear_in && (clear_ch_in == push_ch_in);
    pop_blk  = clear_in && (clear_ch_in == pop_ch_in);
    push_acc = !reset && push_in && !push_blk && !full_out[push_ch_in];
    pop_acc  = !reset && pop_in  && !pop_blk  && !empty_out[pop_ch_in];
    push_rej = !reset && push_in && !push_blk &&  full_out[push_ch_in];
    pop_rej  = !reset && pop_in  && !pop_blk  &&  empty_out[pop_ch_in];
  end

  // One-hot channel decode of this cycle's accepted operations.
  always_comb begin
    push_hit = '0;
    pop_hit  = '0;
    clr_hit  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      push_hit[c] = push_acc && (push_ch_in == CW'(c));
      pop_hit[c]  = pop_acc  && (pop_ch_in  == CW'(c));
      clr_hit[c]  = clear_in && (clear_ch_in == CW'(c));
    end
  end

  // Next pointer and count state per channel; flush overrides everything.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      wp_nxt[c]  = wp_q[c];
      rp_nxt[c]  = rp_q[c];
      cnt_nxt[c] = cnt_q[c];
      if (clr_hit[c]) begin
        wp_nxt[c]  = '0;
        rp_nxt[c]  = '0;
        cnt_nxt[c] = '0;
      end else begin
        if (push_hit[c]) wp_nxt[c] = wp_q[c] + PTR_ONE;
        if (pop_hit[c])  rp_nxt[c] = rp_q[c] + PTR_ONE;
        if (push_hit[c] && !pop_hit[c])
          cnt_nxt[c] = cnt_q[c] + CNT_ONE;
        else if (pop_hit[c] && !push_hit[c])
          cnt_nxt[c] = cnt_q[c] - CNT_ONE;
      end
    end
  end

  // Channel state, almost-full, sticky errors and read-valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wp_q[c]  <= '0;
        rp_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
      afull_out <= '0;
      err_q     <= '0;
      dv_q      <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        wp_q[c]      <= wp_nxt[c];
        rp_q[c]      <= rp_nxt[c];
        cnt_q[c]     <= cnt_nxt[c];
        afull_out[c] <= (cnt_nxt[c] >= CNT_AFULL);
      end
      // A new error in the same cycle wins over the clear request.
      if (push_rej)        err_q[ERR_OVF_BIT] <= 1'b1;
      else if (err_clr_in) err_q[ERR_OVF_BIT] <= 1'b0;
      if (pop_rej)         err_q[ERR_UDF_BIT] <= 1'b1;
      else if (err_clr_in) err_q[ERR_UDF_BIT] <= 1'b0;
      dv_q <= pop_acc;
    end
  end

  // Channel tag for the read data; only meaningful while data_valid_out is high.
  always_ff @(posedge clk) begin
    if (pop_acc) dch_q <= pop_ch_in;
  end

  // Suppress a strobe from a pop that landed just before reset asserted.
  assign data_valid_out = dv_q && !reset;
  assign data_ch_out    = dch_q;
  assign overflow_out   = err_q[ERR_OVF_BIT];
  assign underflow_out  = err_q[ERR_UDF_BIT];

  assign wr_addr = {push_ch_in, wp_q[push_ch_in]};
  assign rd_addr = {pop_ch_in, rp_q[pop_ch_in]};

  mc_fifo_mem #(
    .WIDTH_BYTES(WIDTH_BYTES),
    .DEPTH      (CHANNELS * DEPTH),
    .SHOWAHEAD  (0)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push_acc),
    .wr_addr(wr_addr),
    .wr_data(data_in),
    .rd_en  (pop_acc),
    .rd_addr(rd_addr),
    .rd_data(data_out)
  );

  // Cycle trace for bring-up; inert unless debugen_in is set.
  always_ff @(posedge clk) begin
    if (debugen_in)
      $write("mc_fifo t=%0t push=%b ch=%0d d=%h pop=%b ch=%0d clr=%b | vld=%b och=%0d q=%h ovf=%b udf=%b\n",
             $time, push_in, push_ch_in, data_in, pop_in, pop_ch_in, clear_in,
             data_valid_out, data_ch_out, data_out, overflow_out, underflow_out);
  end

endmodule

// File: doc/mc_fifo.md
MC_FIFO -- requirements
Module: mc_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH_BYTES, default 4, giving the data word width in bytes.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the entries per channel (power of two, >=2).
REQ-003 The block SHALL have parameter CHANNELS, default 4, giving the number of independent queues (power of two, >=2).
REQ-004 The block SHALL have parameter AFULL_THRESH, default 12, giving the almost-full level (1..DEPTH).
REQ-005 The block SHALL have ports as follows, with CW=$clog2(CHANNELS) and LW=$clog2(DEPTH)+1:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- push_in  in  1  write request
- push_ch_in  in  CW  channel to write
- data_in  in  WIDTH_BYTES*8  write data
- pop_in  in  1  read request
- pop_ch_in  in  CW  channel to read; also selects level_out
- data_out  out  WIDTH_BYTES*8  read data
- data_valid_out  out  1  data_out valid strobe
- data_ch_out  out  CW  channel of data_out
- empty_out  out  CHANNELS  per-channel empty
- full_out  out  CHANNELS  per-channel full
- afull_out  out  CHANNELS  per-channel almost-full, registered
- level_out  out  LW  current count of channel pop_ch_in
- clear_in  in  1  flush request
- clear_ch_in  in  CW  channel to flush
- overflow_out  out  1  sticky: push was rejected
- underflow_out  out  1  sticky: pop was rejected
- err_clr_in  in  1  clears both sticky flags
- debugen_in  in  1  enables per-cycle $write trace

Function
REQ-006 Each channel SHALL hold a write pointer, a read pointer ($clog2(DEPTH) bits, wrapping modulo DEPTH) and a count (LW bits, 0..DEPTH).
REQ-007 empty_out[c] SHALL be combinational count==0, and full_out[c] SHALL be combinational count==DEPTH.
REQ-008 A push SHALL be accepted when push_in=1 and the target channel is not full; the block SHALL then write data_in at address {push_ch_in, wp} and increment wp.
REQ-009 A pop SHALL be accepted when pop_in=1 and the target channel is not empty; the block SHALL then read address {pop_ch_in, rp} and increment rp.
REQ-010 The block SHALL drive data_out, data_valid_out=1 and data_ch_out exactly one cycle after an accepted pop; data_valid_out SHALL be 0 otherwise.
REQ-011 A push and a pop to different channels in the same cycle SHALL both be accepted independently.
REQ-012 A push and a pop to the same non-empty, non-full channel SHALL both be accepted, leaving count unchanged.
REQ-013 A push and a pop to the same empty channel SHALL accept the push and reject the pop as an underflow (no bypass).
REQ-014 A push and a pop to the same full channel SHALL accept the pop and reject the push as an overflow.
REQ-015 A rejected push SHALL leave all state unchanged and set overflow_out; a rejected pop SHALL leave all state unchanged, set underflow_out and produce no data_valid_out.
REQ-016 err_clr_in SHALL clear both sticky flags next cycle, and an error in the same cycle SHALL win over the clear.
REQ-017 clear_in SHALL zero wp, rp and count of channel clear_ch_in next cycle.
REQ-018 A push or pop to the cleared channel in the same cycle SHALL be discarded without setting any error flag; other channels SHALL be unaffected.
REQ-019 afull_out[c] SHALL register (next count >= AFULL_THRESH), so it reflects the post-update count one cycle after the change.
REQ-020 level_out SHALL be the combinational count of channel pop_ch_in.
REQ-021 When debugen_in=1, the block SHALL emit one $write per cycle showing push/pop/channel/data/flags; the block SHALL never call $finish.

Reset
REQ-022 On reset, the block SHALL zero all pointers, counts, afull_out, overflow_out, underflow_out and data_valid_out, and set empty_out to all ones and full_out to 0.
REQ-023 data_out and data_ch_out SHALL be undefined until the first data_valid_out.
REQ-024 Reset SHALL dominate push, pop and clear in the same cycle.
REQ-025 A pop accepted in the cycle before reset SHALL produce no data_valid_out.

Structure
REQ-026 Storage SHALL be one existing Memory instance with width WIDTH_BYTES, depth CHANNELS*DEPTH and SHOWAHEAD=0.
REQ-027 The Memory read enable SHALL be gated by pop acceptance and the Memory write enable by push acceptance.
REQ-028 The shared package SHALL hold the CW/LW width-helper functions and the error-flag bit positions; no other sub-module is needed.

Verification
REQ-029 Scenario: push 16 words to ch1 -> full_out=4'b0010, afull_out[1]=1 from the cycle after the 12th push, level_out(ch1)=16.
REQ-030 Scenario: 17th push to ch1 -> overflow_out=1, ch1 data intact; then 16 pops -> words in order, each data_ch_out=1, latency 1 cycle.
REQ-031 Scenario: interleave ch0 push 0xA0.. and ch3 push 0xD0.. -> each channel pops back its own sequence, with pointers wrapping twice.
REQ-032 Scenario: pop empty ch2 with push ch2=0x55 in the same cycle -> underflow_out=1, level(ch2)=1, next pop returns 0x55.
REQ-033 Scenario: ch0 holding 5 words gets clear_in plus push to ch0 -> empty_out[0]=1, no overflow, ch1 contents unaffected.
REQ-034 Scenario: reset asserted mid-stream after a pop -> next cycle data_valid_out=0, empty_out=4'b1111, error flags 0.
